// File: rtl/srl_delay_line.sv
// Runtime-adjustable delay line for DATA_W-bit samples.
// Ports:
//   iclk   - clock, rising edge
//   irst   - asynchronous active-high reset
//   ice    - clock enable for shifting and fill counting
//   id     - input sample, captured into stage 0 when ice=1
//   ilen   - delay select, delay = ilen+1 enabled cycles (clamped to MAX_DEPTH-1)
//   oq     - delayed sample
//   ovalid - oq carries a sample shifted in since reset
//   ofull  - fill count has saturated at MAX_DEPTH
module srl_delay_line #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_DEPTH = 32,
  parameter int unsigned LEN_W     = 5,
  parameter int unsigned OUT_REG   = 0
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              ice,
  input  logic [DATA_W-1:0] id,
  input  logic [LEN_W-1:0]  ilen,
  output logic [DATA_W-1:0] oq,
  output logic              ovalid,
  output logic              ofull
);

  localparam int unsigned CNT_W   = LEN_W + 1;
  localparam int unsigned IDX_W   = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int unsigned MAX_LEN = MAX_DEPTH - 1;

  logic [DATA_W-1:0] sr_q [MAX_DEPTH];
  logic [DATA_W-1:0] sr_d [MAX_DEPTH];
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic              ofull_q;
  logic [DATA_W-1:0] sel_q;
  logic              sel_v;

  // Clamp the requested length so the stage select never leaves the array
  always_comb begin
    len_d = ilen;
    if (32'(ilen) > MAX_LEN) begin
      len_d = LEN_W'(MAX_LEN);
    end
  end

  // Shift chain next state; stages hold when ice is low
  always_comb begin
    sr_d = sr_q;
    if (ice) begin
      sr_d[0] = id;
      for (int i = 1; i < int'(MAX_DEPTH); i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end
  end

  // Fill counter saturates at MAX_DEPTH so it never wraps
  always_comb begin
    fill_d = fill_q;
    if (ice && (fill_q != CNT_W'(MAX_DEPTH))) begin
      fill_d = fill_q + CNT_W'(1);
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      for (int i = 0; i < int'(MAX_DEPTH); i++) begin
        sr_q[i] <= '0;
      end
      len_q   <= '0;
      fill_q  <= '0;
      ofull_q <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      ofull_q <= (fill_d == CNT_W'(MAX_DEPTH));
    end
  end

  // Selection depends on registers only, so there is no id/ilen to oq path
  assign sel_q = sr_q[IDX_W'(len_q)];
  assign sel_v = (fill_q > CNT_W'(len_q));
  assign ofull = ofull_q;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] oq_q;
      logic              ovalid_q;

      // Output register runs every clock, not gated by ice
      always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
          oq_q     <= '0;
          ovalid_q <= 1'b0;
        end else begin
          oq_q     <= sel_q;
          ovalid_q <= sel_v;
        end
      end

      assign oq     = oq_q;
      assign ovalid = ovalid_q;
    end else begin : g_comb
      assign oq     = sel_q;
      assign ovalid = sel_v;
    end
  endgenerate

endmodule

// File: tb/tb_srl_delay_line.sv
// Bench for srl_delay_line: three instances (default, output register, MAX_DEPTH=24)
// share one stimulus; a sample-history model predicts every output each cycle.
module tb_srl_delay_line;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       ice  = 1'b0;
  logic [7:0] id   = 8'h00;
  logic [4:0] ilen = 5'd0;

  logic [7:0] q0, q1, q2;
  logic       v0, v1, v2;
  logic       f0, f1, f2;

  int  n_cmp  = 0;
  int  n_bad  = 0;
  bit  chk_en = 1'b0;

  always #5 clk = ~clk;

  srl_delay_line #(.DATA_W(8), .MAX_DEPTH(32), .LEN_W(5), .OUT_REG(0)) dut0 (
    .iclk(clk), .irst(rst), .ice(ice), .id(id), .ilen(ilen),
    .oq(q0), .ovalid(v0), .ofull(f0));

  srl_delay_line #(.DATA_W(8), .MAX_DEPTH(32), .LEN_W(5), .OUT_REG(1)) dut1 (
    .iclk(clk), .irst(rst), .ice(ice), .id(id), .ilen(ilen),
    .oq(q1), .ovalid(v1), .ofull(f1));

  srl_delay_line #(.DATA_W(8), .MAX_DEPTH(24), .LEN_W(5), .OUT_REG(0)) dut2 (
    .iclk(clk), .irst(rst), .ice(ice), .id(id), .ilen(ilen),
    .oq(q2), .ovalid(v2), .ofull(f2));

  // Model: hist[j] is the sample accepted j enabled edges ago (0 before reset)
  logic [7:0] hist [256];
  int         fill32, fill24, len32, len24;
  logic [7:0] r_q;
  logic       r_v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) hist[i] = 8'h00;
      fill32 = 0; fill24 = 0; len32 = 0; len24 = 0;
      r_q = 8'h00; r_v = 1'b0;
    end else begin
      r_q = hist[len32];
      r_v = (fill32 > len32);
      if (ice) begin
        for (int i = 255; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = id;
        if (fill32 < 32) fill32 = fill32 + 1;
        if (fill24 < 24) fill24 = fill24 + 1;
      end
      len32 = (int'(ilen) > 31) ? 31 : int'(ilen);
      len24 = (int'(ilen) > 23) ? 23 : int'(ilen);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_q0", 32'(q0), 32'(hist[len32]));
      chk("m_v0", 32'(v0), 32'(fill32 > len32));
      chk("m_f0", 32'(f0), 32'(fill32 == 32));
      chk("m_q1", 32'(q1), 32'(r_q));
      chk("m_v1", 32'(v1), 32'(r_v));
      chk("m_f1", 32'(f1), 32'(fill32 == 32));
      chk("m_q2", 32'(q2), 32'(hist[len24]));
      chk("m_v2", 32'(v2), 32'(fill24 > len24));
      chk("m_f2", 32'(f2), 32'(fill24 == 24));
    end
  end

  task automatic step(input logic [7:0] d, input logic ce, input logic [4:0] l);
    id   = d;
    ice  = ce;
    ilen = l;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_q0"}, 32'(q0), 32'd0);
    chk({tag, "_v0"}, 32'(v0), 32'd0);
    chk({tag, "_f0"}, 32'(f0), 32'd0);
    chk({tag, "_q1"}, 32'(q1), 32'd0);
    chk({tag, "_v1"}, 32'(v1), 32'd0);
    chk({tag, "_f1"}, 32'(f1), 32'd0);
    chk({tag, "_q2"}, 32'(q2), 32'd0);
    chk({tag, "_v2"}, 32'(v2), 32'd0);
    chk({tag, "_f2"}, 32'(f2), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("rst");
    rst    = 1'b0;
    chk_en = 1'b1;

    // Fixed ilen=4, ramp input: first sample emerges after 5 enabled edges
    for (int k = 1; k <= 40; k++) begin
      step(8'(k), 1'b1, 5'd4);
      if (k == 4) begin
        chk("s1_k4_q0", 32'(q0), 32'd0);
        chk("s1_k4_v0", 32'(v0), 32'd0);
      end
      if (k == 5) begin
        chk("s1_k5_q0", 32'(q0), 32'd1);
        chk("s1_k5_v0", 32'(v0), 32'd1);
        chk("s1_k5_v1", 32'(v1), 32'd0);
      end
      if (k == 6) begin
        chk("s1_k6_q1", 32'(q1), 32'd1);
        chk("s1_k6_v1", 32'(v1), 32'd1);
      end
      if (k == 10) chk("s1_k10_q0", 32'(q0), 32'd6);
      if (k == 23) chk("s1_k23_f2", 32'(f2), 32'd0);
      if (k == 24) chk("s1_k24_f2", 32'(f2), 32'd1);
      if (k == 31) chk("s1_k31_f0", 32'(f0), 32'd0);
      if (k == 32) begin
        chk("s1_k32_f0", 32'(f0), 32'd1);
        chk("s1_k32_f1", 32'(f1), 32'd1);
      end
      if (k == 40) chk("s1_k40_q0", 32'(q0), 32'd36);
    end

    // Full pipeline at ilen=10, then retarget the length with ice low
    for (int k = 1; k <= 40; k++) step(8'(100 + k), 1'b1, 5'd10);
    chk("s4_l10_q0", 32'(q0), 32'd130);
    step(8'hEE, 1'b0, 5'd20);
    chk("s4_l20_q0", 32'(q0), 32'd120);
    chk("s4_l20_v0", 32'(v0), 32'd1);
    step(8'hEE, 1'b0, 5'd0);
    chk("s4_l0_q0", 32'(q0), 32'd140);
    chk("s4_l0_q1", 32'(q1), 32'd120);
    step(8'hEE, 1'b0, 5'd31);
    chk("s5_l31_q0", 32'(q0), 32'd109);
    chk("s5_l31_q2", 32'(q2), 32'd117);
    chk("s5_l31_v2", 32'(v2), 32'd1);

    // Short asynchronous reset pulse between edges
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_all_zero("arst");
    rst = 1'b0;

    // Refill after reset matches the first scenario
    for (int k = 1; k <= 6; k++) begin
      step(8'(k), 1'b1, 5'd4);
      if (k == 4) chk("s6_k4_v0", 32'(v0), 32'd0);
      if (k == 5) begin
        chk("s6_k5_q0", 32'(q0), 32'd1);
        chk("s6_k5_v0", 32'(v0), 32'd1);
      end
    end

    // Length increase before fill drops ovalid until enough shifts
    step(8'd7, 1'b1, 5'd9);
    chk("grow_v0", 32'(v0), 32'd0);
    step(8'd8, 1'b1, 5'd9);
    step(8'd9, 1'b1, 5'd9);
    step(8'd10, 1'b1, 5'd9);
    chk("grow_q0", 32'(q0), 32'd1);
    chk("grow_v0b", 32'(v0), 32'd1);

    // Clock-enable toggling at ilen=2
    rst = 1'b1;
    step(8'h00, 1'b0, 5'd2);
    rst = 1'b0;
    step(8'd1, 1'b1, 5'd2);
    step(8'hAA, 1'b0, 5'd2);
    step(8'd2, 1'b1, 5'd2);
    step(8'hBB, 1'b0, 5'd2);
    chk("ce_c4_q0", 32'(q0), 32'd0);
    chk("ce_c4_v0", 32'(v0), 32'd0);
    step(8'd3, 1'b1, 5'd2);
    chk("ce_c5_q0", 32'(q0), 32'd1);
    chk("ce_c5_v0", 32'(v0), 32'd1);
    step(8'hCC, 1'b0, 5'd2);
    chk("ce_hold_q0", 32'(q0), 32'd1);
    step(8'hCC, 1'b0, 5'd0);
    chk("ce_shrink_q0", 32'(q0), 32'd3);
    chk("ce_shrink_v0", 32'(v0), 32'd1);
    step(8'hCC, 1'b0, 5'd0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/srl_delay_line.md
Name: srl_delay_line

Overview:
Parametrised, runtime-adjustable delay line for DATA_W-bit samples. It replaces fixed-length flip-flop delay chains. Features:
- Delay selectable from 1 to MAX_DEPTH clock-enabled cycles via a length input.
- Optional output register.
- Fill tracking, so downstream logic knows when the output carries real delayed data rather than reset contents.
- Sits in datapath alignment paths, e.g. matching the latency of a parallel pipeline branch.

Parameters:
DATA_W, 8, sample width in bits (>=1)
MAX_DEPTH, 32, number of shift stages / maximum delay (2..256)
LEN_W, 5, width of ilen; must be >= ceil(log2(MAX_DEPTH))
OUT_REG, 0, 0 = oq/ovalid driven directly from the selected stage; 1 = extra output register, +1 clock latency

Ports:
iclk  in  1  clock, all logic on rising edge
irst  in  1  reset, asynchronous, active-high
ice   in  1  clock enable for shifting and fill counting
id    in  DATA_W  input sample, captured into stage 0 when ice=1
ilen  in  LEN_W  delay select; delay = ilen+1 enabled cycles
oq    out  DATA_W  delayed sample
ovalid  out  1  high when oq holds a sample shifted in since reset
ofull  out  1  high when fill count has saturated at MAX_DEPTH

Behaviour:
Reset (irst=1, asynchronous, immediate regardless of iclk):
- All stages sr[0..MAX_DEPTH-1] = 0.
- fill_cnt = 0, len_r = 0.
- oq = 0, ovalid = 0, ofull = 0, including the OUT_REG register.
- Reset asserted mid-operation discards all contents.
- First shift is on the first rising edge with irst=0 and ice=1.

Length register:
- len_r <= min(ilen, MAX_DEPTH-1) every clock, independent of ice.
- ilen values >= MAX_DEPTH clamp to MAX_DEPTH-1.
- A length change takes effect on oq one clock after ilen changes.
- Stage contents are not disturbed by a length change.

Shift, on a rising edge with ice=1:
- sr[0] <= id.
- sr[i] <= sr[i-1] for i = 1..MAX_DEPTH-1.
- With ice=0, all stages and fill_cnt hold.

Fill counter:
- fill_cnt is (LEN_W+1) bits wide.
- Increments on each ice=1 edge and saturates at MAX_DEPTH.

Selection and outputs:
- sel_q = sr[len_r]; sel_v = (fill_cnt > len_r).
- OUT_REG=0: oq = sel_q and ovalid = sel_v, combinational from registers only (no path from id/ilen to oq).
- OUT_REG=1: oq <= sel_q and ovalid <= sel_v on every clock, not gated by ice.
- ofull = (fill_cnt == MAX_DEPTH), registered.

Latency:
- A sample accepted at enabled edge k appears on oq after enabled edge k+len_r (OUT_REG=0).
- With OUT_REG=1 it appears one clock later.
- len_r=0 gives 1-cycle delay, matching a single flip-flop.

Boundary conditions:
- Length increase after fill: older samples are already present, so ovalid stays 1 if fill_cnt > new len_r.
- Length increase before fill: ovalid may fall back to 0 until enough shifts have occurred.
- Length decrease: output jumps to the newer sample; ovalid never falls.
- Simultaneous ilen change and ice=1: shift uses the current stages; selection uses len_r updated on the same edge.
- ice held low: oq and ovalid are stable, except when ilen changes.
- fill_cnt never wraps.

Test Plan:
1. Reset then hold ilen=4, ice=1, id=1,2,3,... each clock (OUT_REG=0) -> oq=0/ovalid=0 for the first 4 clocks after the first shift; id=1 appears on oq after the 5th enabled edge with ovalid=1; oq then increments by 1 per clock.
2. Repeat scenario 1 with OUT_REG=1 -> identical sequence, one clock later; ofull asserts after exactly 32 enabled edges.
3. ice toggled 1,0,1,0 with ilen=2 -> oq advances only on enabled edges; id=1 emerges after 3 enabled edges (5 clocks); stages hold while ice=0.
4. Full pipeline at ilen=10: switch ilen to 20 -> oq shows the sample 21 enabled cycles old on the next clock, ovalid stays 1. Switch to 0 -> oq shows the most recent sample.
5. MAX_DEPTH=24, LEN_W=5, ilen=31 -> behaves as ilen=23: 24-cycle delay, no X or out-of-range select.
6. Assert irst for 1 ns between edges mid-stream -> oq, ovalid and ofull go to 0 immediately, without a clock edge. After release, the refill timing matches scenario 1.
